// File: rtl/shift_and_subtract_binary_divider_if.sv
// shift_and_subtract_binary_divider_if: request/result bundle for the divider
// master drives start/A/B; slave returns Q/R/busy/done/div_by_zero.
interface shift_and_subtract_binary_divider_if #(
    parameter int m = 8,
    parameter int n = 8
);
    logic         start;
    logic [m-1:0] A;
    logic [n-1:0] B;
    logic [m-1:0] Q;
    logic [n-1:0] R;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    modport master (output start, A, B, input Q, R, busy, done, div_by_zero);
    modport slave  (input start, A, B, output Q, R, busy, done, div_by_zero);
endinterface

// File: rtl/shift_and_subtract_binary_divider.sv
// shift_and_subtract_binary_divider: unsigned restoring divider, one quotient bit per cycle
// Ports: clk (rising edge), rst (async, active-low), bus (slave modport):
//   start/A/B in; Q/R results, busy (RUN/DONE), done (1-cycle pulse), div_by_zero.
// Option: define DIV_ZERO_DETECT_EN to short-cut B=0 straight to DONE with div_by_zero=1.
module shift_and_subtract_binary_divider #(
    parameter int m = 8,
    parameter int n = 8
) (
    input logic clk,
    input logic rst,
    shift_and_subtract_binary_divider_if.slave bus
);
    localparam int CW = (m > 1) ? $clog2(m) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state;
    logic [m-1:0]  a_sh;
    logic [n-1:0]  b_r;
    logic [n-1:0]  rem;
    logic [n-1:0]  sub;
    logic [n-1:0]  rem_nxt;
    logic [n:0]    rs;
    logic [CW-1:0] cnt;
    logic          neg;
    // a_sh shifts dividend bits out of its MSB while quotient bits enter at the LSB
    always_comb begin
        rs      = {rem, a_sh[m-1]};
        neg     = rs < {1'b0, b_r};
        sub     = rs[n-1:0] - b_r;
        rem_nxt = neg ? rs[n-1:0] : sub;
    end
`ifdef DIV_ZERO_DETECT_EN
    logic dz;
    assign bus.div_by_zero = dz;
`else
    assign bus.div_by_zero = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_r      <= '0;
            rem      <= '0;
            cnt      <= '0;
            bus.Q    <= '0;
            bus.R    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz       <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    a_sh     <= bus.A;
                    b_r      <= bus.B;
                    rem      <= '0;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                    state    <= RUN;
`ifdef DIV_ZERO_DETECT_EN
                    if (bus.B == '0) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.Q    <= '1;
                        bus.R    <= bus.A[n-1:0];
                        dz       <= 1'b1;
                    end
`endif
                end
                RUN: begin
                    a_sh <= {a_sh[m-2:0], ~neg};
                    rem  <= rem_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(m - 1)) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.Q    <= {a_sh[m-2:0], ~neg};
                        bus.R    <= rem_nxt;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                    dz       <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
// tb_shift_and_subtract_binary_divider: directed and random checks of the divider against an arithmetic model
module tb_shift_and_subtract_binary_divider;
    localparam int M = 8;
    localparam int N = 8;
    logic clk;
    logic rst;
    int   passes;
    int   total;
    shift_and_subtract_binary_divider_if #(.m(M), .n(N)) bus ();
    shift_and_subtract_binary_divider #(.m(M), .n(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output int lat, output int dz);
        lat = M + 1;
        dz  = 0;
        if (b == 0) begin
            q = (1 << M) - 1;
            r = a % (1 << N);
`ifdef DIV_ZERO_DETECT_EN
            lat = 1;
            dz  = 1;
`endif
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction
    // Called just after a clock edge with the divider idle; rp>0 re-pulses start at that cycle.
    task automatic run(input int a, input int b, input int rp, input bit hold);
        int eq, er, el, ed, lat;
        logic [M-1:0] q0;
        logic [N-1:0] r0;
        model(a, b, eq, er, el, ed);
        q0 = bus.Q;
        r0 = bus.R;
        lat = 0;
        bus.A = M'(a);
        bus.B = N'(b);
        bus.start = 1'b1;
        for (int k = 1; k <= 4 * M && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 && !hold) bus.start = 1'b0;
            if (k == rp) begin
                bus.start = 1'b1;
                bus.A = 8'd10;
                bus.B = 8'd2;
            end
            if (rp > 0 && k == rp + 1) bus.start = 1'b0;
            if (bus.done) lat = k;
            else if (k == 3) begin
                chk("busy_in_run", bus.busy, 1);
                chk("q_held_in_run", bus.Q, q0);
                chk("r_held_in_run", bus.R, r0);
            end
        end
        chk("latency", lat, el);
        chk("quotient", bus.Q, eq);
        chk("remainder", bus.R, er);
        chk("div_by_zero", bus.div_by_zero, ed);
        chk("busy_at_done", bus.busy, 1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", bus.done, 0);
        chk("idle_after_done", bus.busy, 0);
    endtask
    initial begin
        passes = 0;
        total = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", bus.Q, 0);
        chk("rst_r", bus.R, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dz", bus.div_by_zero, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run(100, 7, 0, 0);
        run(255, 1, 0, 0);
        run(5, 9, 0, 0);
        run(37, 0, 0, 0);
        run(200, 3, 4, 0);
        run(0, 255, 0, 0);
        run(254, 255, 0, 0);
        // start held high: ignored in DONE, next division begins on the following IDLE cycle
        run(77, 5, 0, 1);
        run(91, 13, 0, 0);
        // reset in the middle of RUN aborts without a done pulse
        bus.A = 8'd170;
        bus.B = 8'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_q", bus.Q, 0);
        chk("abort_r", bus.R, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_dz", bus.div_by_zero, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("no_done_in_reset", bus.done, 0);
        end
        rst = 1'b1;
        for (int i = 0; i < M + 2; i++) begin
            @(posedge clk);
            #1;
            chk("no_done_after_abort", bus.done, 0);
        end
        run(50, 6, 0, 0);
        for (int i = 0; i < 24; i++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            run(a, b, 0, 0);
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/shift_and_subtract_binary_divider.md
SHIFT_AND_SUBTRACT_BINARY_DIVIDER -- requirements
Module: shift_and_subtract_binary_divider

Interface
REQ-001 SHALL have parameter: m, 8, dividend and quotient width.
REQ-002 SHALL have parameter: n, 8, divisor and remainder width.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  request a division, sampled in IDLE only.
REQ-006 SHALL have port: A  input  m  dividend, captured when start is accepted.
REQ-007 SHALL have port: B  input  n  divisor, captured when start is accepted.
REQ-008 SHALL have port: Q  output  m  quotient register.
REQ-009 SHALL have port: R  output  n  remainder register.
REQ-010 SHALL have port: busy  output  1  high in RUN and DONE states.
REQ-011 SHALL have port: done  output  1  one-cycle pulse marking valid Q/R.
REQ-012 SHALL have port: div_by_zero  output  1  high with done when the captured B was 0.

Function
REQ-013 SHALL implement unsigned restoring shift-and-subtract division: A = Q*B + R, with R < B for B != 0.
REQ-014 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-015 IDLE: when start=1 at a clk edge, SHALL capture A and B, clear the working remainder (n+1 bits), and go to RUN.
REQ-016 RUN: each cycle, SHALL shift {remainder, dividend MSB} left by one, subtract B, and keep the difference with quotient bit 1 if the result is non-negative, else restore it with quotient bit 0.
REQ-017 RUN SHALL last exactly m cycles, counted by an internal iteration counter, then go to DONE.
REQ-018 DONE: SHALL update Q/R, assert done for exactly one cycle, then return to IDLE.
REQ-019 Latency: done SHALL be high in the cycle m+1 edges after start is accepted (9 cycles at m=8).
REQ-020 Q and R SHALL hold their last values until the next DONE; they SHALL NOT change during RUN.
REQ-021 start SHALL be ignored while busy=1; A and B changes during RUN SHALL have no effect.
REQ-022 start=1 in the DONE cycle SHALL be ignored; start held high SHALL begin a new division on the following IDLE cycle.
REQ-023 B=0 without zero detection SHALL produce Q = all ones and R = A[n-1:0] through the normal m-cycle path.
REQ-024 done and div_by_zero SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, Q=0, R=0, busy=0, done=0, div_by_zero=0, and clear the counter and working registers.
REQ-026 Reset during RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL run normally.

Configuration
REQ-027 Macro DIV_ZERO_DETECT_EN defined: B=0 at accept SHALL go IDLE->DONE directly, so done is high 1 cycle after accept.
REQ-028 In that DONE cycle (DIV_ZERO_DETECT_EN defined), Q SHALL be all ones, R SHALL be A[n-1:0], and div_by_zero SHALL be 1.
REQ-029 Macro DIV_ZERO_DETECT_EN undefined: div_by_zero SHALL be tied 0, and B=0 SHALL follow REQ-023 with normal latency.

Verification
REQ-030 A=100, B=7, start one cycle -> after 9 cycles done=1, Q=14, R=2, div_by_zero=0.
REQ-031 A=255, B=1 -> Q=255, R=0; then A=5, B=9 -> Q=0, R=5; done pulses exactly once each.
REQ-032 A=37, B=0 with DIV_ZERO_DETECT_EN -> done 1 cycle after accept, Q=255, R=37, div_by_zero=1.
REQ-033 A=37, B=0 without DIV_ZERO_DETECT_EN -> done after 9 cycles, Q=255, R=37, div_by_zero=0.
REQ-034 A=200, B=3 started, start re-pulsed with A=10, B=2 at cycle 4 -> Q=66, R=2; second request ignored.
REQ-035 rst=0 asserted at cycle 5 of RUN -> outputs 0 immediately, no done; then A=50, B=6 -> Q=8, R=2.
